// File: rtl/sop_sharelogic_eval_ctrl_if.sv
// Config/sweep handshake bundle between a controller and the SOP evaluator.
interface sop_sharelogic_eval_ctrl_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
);
  logic             cfg_valid;
  logic             cfg_bit;
  logic             cfg_ready;
  logic             cfg_loaded;
  logic             start;
  logic             busy;
  logic [N_IN-1:0]  cur_vec;
  logic             done;
  logic [N_OUT-1:0] max_err;
  logic [N_IN:0]    err_count;
  logic             pass;

  modport master (
    output cfg_valid, cfg_bit, start,
    input  cfg_ready, cfg_loaded, busy, cur_vec, done, max_err, err_count, pass
  );

  modport slave (
    input  cfg_valid, cfg_bit, start,
    output cfg_ready, cfg_loaded, busy, cur_vec, done, max_err, err_count, pass
  );
endinterface

// File: rtl/sop_sharelogic_eval_ctrl.sv
// Loads a serial SOP shared-logic config, sweeps all input vectors through the approximate
// adder and accumulates worst-case error and erroneous-vector count against the exact sum.
module sop_sharelogic_eval_ctrl #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3,
  parameter int PIT   = 2,
  parameter int ET    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  sop_sharelogic_eval_ctrl_if.slave bus
);
  localparam int CFG_W   = 2*PIT*N_IN + PIT*N_OUT + N_OUT;
  localparam int CNT_W   = $clog2(CFG_W + 1);
  localparam int OFF_POL = PIT*N_IN;
  localparam int OFF_SEL = 2*PIT*N_IN;
  localparam int OFF_EN  = OFF_SEL + PIT*N_OUT;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SWEEP, S_DRAIN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [CFG_W-1:0]   cfg_q;
  logic [CNT_W-1:0]   bit_cnt;
  logic               cfg_loaded;
  logic               cfg_ready;
  logic               cfg_acc;
  logic               last_bit;
  logic               busy;
  logic               done;
  logic               drain_cnt;
  logic [N_IN-1:0]    cur_vec;
  logic               err_vld;
  logic [N_OUT-1:0]   err_q;
  logic [N_OUT-1:0]   max_err;
  logic [N_IN:0]      err_count;
  logic               pass;

  assign cfg_acc  = bus.cfg_valid & cfg_ready;
  assign last_bit = cfg_acc && (bit_cnt == CNT_W'(CFG_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (bus.cfg_valid)                  state_nxt = last_bit ? S_IDLE : S_LOAD;
        else if (bus.start && cfg_loaded)   state_nxt = S_SWEEP;
      end
      S_LOAD: begin
        cfg_ready = 1'b1;
        busy      = 1'b1;
        if (last_bit) state_nxt = S_IDLE;
      end
      S_SWEEP: begin
        busy = 1'b1;
        if (cur_vec == '1) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shifting in from the top puts bit k at index k once all CFG_W bits are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q      <= '0;
      bit_cnt    <= '0;
      cfg_loaded <= 1'b0;
    end else if (cfg_acc) begin
      cfg_q <= (cfg_q >> 1) | (CFG_W'(bus.cfg_bit) << (CFG_W - 1));
      if (last_bit) begin
        bit_cnt    <= '0;
        cfg_loaded <= 1'b1;
      end else begin
        bit_cnt    <= bit_cnt + CNT_W'(1);
        cfg_loaded <= 1'b0;
      end
    end
  end

  // Approximate datapath, evaluated on the registered vector.
  logic [PIT-1:0]   prod;
  logic [N_OUT-1:0] approx;

  for (genvar p = 0; p < PIT; p++) begin : g_prod
    logic [N_IN-1:0] use_p, pol_p;
    assign use_p   = cfg_q[p*N_IN +: N_IN];
    assign pol_p   = cfg_q[OFF_POL + p*N_IN +: N_IN];
    assign prod[p] = (|use_p) & (&(~use_p | (cur_vec ^ pol_p)));
  end

  for (genvar o = 0; o < N_OUT; o++) begin : g_out
    logic [PIT-1:0] hit;
    for (genvar p = 0; p < PIT; p++) begin : g_hit
      assign hit[p] = cfg_q[OFF_SEL + p*N_OUT + o] & prod[p];
    end
    assign approx[o] = cfg_q[OFF_EN + o] & (|hit);
  end

  logic [N_OUT-1:0]      exact;
  logic signed [N_OUT:0] diff;
  logic signed [N_OUT:0] mag;

  assign exact = N_OUT'(cur_vec[N_IN/2-1:0]) + N_OUT'(cur_vec[N_IN-1:N_IN/2]);
  assign diff  = $signed({1'b0, approx}) - $signed({1'b0, exact});
  assign mag   = diff[N_OUT] ? -diff : diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_vec   <= '0;
      drain_cnt <= 1'b0;
      err_vld   <= 1'b0;
      err_q     <= '0;
    end else begin
      cur_vec   <= (state == S_SWEEP) ? cur_vec + N_IN'(1) : '0;
      drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
      err_vld   <= (state == S_SWEEP);
      err_q     <= mag[N_OUT-1:0];
    end
  end

  // Accumulators trail the vector by two stages; pass latches on the DRAIN->DONE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_err   <= '0;
      err_count <= '0;
      pass      <= 1'b0;
    end else if (state == S_IDLE && state_nxt == S_SWEEP) begin
      max_err   <= '0;
      err_count <= '0;
      pass      <= 1'b0;
    end else begin
      if (err_vld) begin
        if (err_q > max_err) max_err <= err_q;
        if (err_q != '0)     err_count <= err_count + (N_IN+1)'(1);
      end
      if (state == S_DRAIN && drain_cnt) pass <= (int'(max_err) <= ET);
    end
  end

  assign bus.cfg_ready  = cfg_ready;
  assign bus.cfg_loaded = cfg_loaded;
  assign bus.busy       = busy;
  assign bus.cur_vec    = cur_vec;
  assign bus.done       = done;
  assign bus.max_err    = max_err;
  assign bus.err_count  = err_count;
  assign bus.pass       = pass;
endmodule

// File: tb/tb_sop_sharelogic_eval_ctrl.sv
// Scoreboarded bench: two evaluators (ET=4 and ET=3) share one stimulus stream.
module tb_sop_sharelogic_eval_ctrl;
  localparam int N_IN    = 4;
  localparam int N_OUT   = 3;
  localparam int PIT     = 2;
  localparam int ET_HI   = 4;
  localparam int ET_LO   = 3;
  localparam int CFG_W   = 2*PIT*N_IN + PIT*N_OUT + N_OUT;
  localparam int OFF_POL = PIT*N_IN;
  localparam int OFF_SEL = 2*PIT*N_IN;
  localparam int OFF_EN  = OFF_SEL + PIT*N_OUT;
  localparam int NVEC    = 1 << N_IN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_bit = 1'b0;
  logic start = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sop_sharelogic_eval_ctrl_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus_a ();
  sop_sharelogic_eval_ctrl_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus_b ();

  assign bus_a.cfg_valid = cfg_valid;
  assign bus_a.cfg_bit   = cfg_bit;
  assign bus_a.start     = start;
  assign bus_b.cfg_valid = cfg_valid;
  assign bus_b.cfg_bit   = cfg_bit;
  assign bus_b.start     = start;

  sop_sharelogic_eval_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .PIT(PIT), .ET(ET_HI)) dut_hi (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  sop_sharelogic_eval_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .PIT(PIT), .ET(ET_LO)) dut_lo (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  typedef struct {
    int t_done;
    int mx;
    int cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference: evaluate the configured SOP per vector straight from the field definitions.
  function automatic void model(input logic [CFG_W-1:0] c, output int mx, output int cnt);
    mx  = 0;
    cnt = 0;
    for (int v = 0; v < NVEC; v++) begin
      int a, b, exact, approx, err;
      a      = v % (1 << (N_IN/2));
      b      = v >> (N_IN/2);
      exact  = a + b;
      approx = 0;
      for (int o = 0; o < N_OUT; o++) begin
        bit on;
        on = 0;
        for (int p = 0; p < PIT; p++) begin
          int nlit;
          bit all_true;
          nlit = 0;
          all_true = 1;
          for (int i = 0; i < N_IN; i++) begin
            if (c[p*N_IN + i]) begin
              nlit++;
              if (((v >> i) & 1) == int'(c[OFF_POL + p*N_IN + i])) all_true = 0;
            end
          end
          if (c[OFF_SEL + p*N_OUT + o] && nlit > 0 && all_true) on = 1;
        end
        if (c[OFF_EN + o] && on) approx += (1 << o);
      end
      err = (approx > exact) ? approx - exact : exact - approx;
      if (err > mx) mx = err;
      if (err != 0) cnt++;
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (bus_a.done || bus_b.done)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d: got done=1, expected 0", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.t_done);
        chk("done_both", int'(bus_a.done & bus_b.done), 1);
        chk("max_err", int'(bus_a.max_err), e.mx);
        chk("err_count", int'(bus_a.err_count), e.cnt);
        chk("pass_et4", int'(bus_a.pass), int'(e.mx <= ET_HI));
        chk("max_err_et3", int'(bus_b.max_err), e.mx);
        chk("pass_et3", int'(bus_b.pass), int'(e.mx <= ET_LO));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bits(input logic [CFG_W-1:0] c, input int from, input int to);
    for (int k = from; k < to; k++) begin
      cfg_valid = 1'b1;
      cfg_bit   = c[k];
      tick();
    end
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cfg_ready"}, int'(bus_a.cfg_ready), 1);
    chk({tag, "_cfg_loaded"}, int'(bus_a.cfg_loaded), 0);
    chk({tag, "_busy"}, int'(bus_a.busy), 0);
    chk({tag, "_done"}, int'(bus_a.done), 0);
    chk({tag, "_cur_vec"}, int'(bus_a.cur_vec), 0);
    chk({tag, "_max_err"}, int'(bus_a.max_err), 0);
    chk({tag, "_err_count"}, int'(bus_a.err_count), 0);
    chk({tag, "_pass"}, int'(bus_a.pass), 0);
  endtask

  // Issues start, checks the vector stream, optionally disturbs the bus mid-sweep.
  task automatic run(input int mx, input int cnt, input bit disturb);
    exp_t x;
    x.t_done = cyc + NVEC + 3;
    x.mx     = mx;
    x.cnt    = cnt;
    sb.push_back(x);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (disturb) cfg_valid = 1'b1;
    for (int v = 0; v < NVEC; v++) begin
      chk("cur_vec", int'(bus_a.cur_vec), v);
      chk("busy_sweep", int'(bus_a.busy), 1);
      chk("cfg_ready_sweep", int'(bus_a.cfg_ready), 0);
      if (disturb) begin
        cfg_bit = 1'($urandom);
        start   = (v == 5);
        if (v == 10) cfg_valid = 1'b0;
      end
      tick();
    end
    start     = 1'b0;
    cfg_valid = 1'b0;
    chk("cur_vec_wrap", int'(bus_a.cur_vec), 0);
    repeat (4) tick();
    chk("busy_after", int'(bus_a.busy), 0);
  endtask

  task automatic load_and_run(input logic [CFG_W-1:0] c);
    int mx, cnt;
    model(c, mx, cnt);
    load_bits(c, 0, CFG_W);
    chk("cfg_loaded", int'(bus_a.cfg_loaded), 1);
    run(mx, cnt, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [CFG_W-1:0] cfg_spec;
    logic [CFG_W-1:0] c;
    int mx, cnt;

    cfg_spec = '0;
    cfg_spec[0*N_IN + 1]           = 1'b1;
    cfg_spec[1*N_IN + 0]           = 1'b1;
    cfg_spec[1*N_IN + 1]           = 1'b1;
    cfg_spec[OFF_POL + 1*N_IN + 1] = 1'b1;
    cfg_spec[OFF_SEL + 0*N_OUT + 1] = 1'b1;
    cfg_spec[OFF_SEL + 0*N_OUT + 2] = 1'b1;
    cfg_spec[OFF_SEL + 1*N_OUT + 2] = 1'b1;
    cfg_spec[OFF_EN + 1]           = 1'b1;
    cfg_spec[OFF_EN + 2]           = 1'b1;

    repeat (2) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // start with nothing loaded is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("noload_busy", int'(bus_a.busy), 0);
    repeat (22) tick();
    chk("noload_busy_late", int'(bus_a.busy), 0);
    chk("noload_max_err", int'(bus_a.max_err), 0);

    // directed configuration with known results
    load_bits(cfg_spec, 0, CFG_W);
    chk("spec_cfg_loaded", int'(bus_a.cfg_loaded), 1);
    run(4, 13, 1'b0);

    load_bits('0, 0, CFG_W);
    run(6, 15, 1'b0);

    // config traffic and a second start during the sweep are ignored
    load_bits(cfg_spec, 0, CFG_W);
    run(4, 13, 1'b1);
    run(4, 13, 1'b0);

    // reset in the middle of a sweep
    c = CFG_W'($urandom);
    model(c, mx, cnt);
    load_bits(c, 0, CFG_W);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_reset_outputs("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    load_and_run(c);

    // partial load then start is ignored; completing the load works
    c = CFG_W'($urandom);
    model(c, mx, cnt);
    load_bits(c, 0, 12);
    chk("partial_cfg_loaded", int'(bus_a.cfg_loaded), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("partial_cfg_ready", int'(bus_a.cfg_ready), 1);
    tick();
    chk("partial_cur_vec", int'(bus_a.cur_vec), 0);
    load_bits(c, 12, CFG_W);
    chk("partial_cfg_loaded_done", int'(bus_a.cfg_loaded), 1);
    run(mx, cnt, 1'b0);

    // randomized configurations
    for (int r = 0; r < 8; r++) begin
      c = CFG_W'($urandom);
      load_and_run(c);
    end

    repeat (5) tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sop_sharelogic_eval_ctrl.md
# sop_sharelogic_eval_ctrl

Configures and sequences an SOP shared-logic approximate adder (PIT shared products, N_OUT outputs) and exhaustively evaluates it against the exact adder. A serial config port loads literal, product-selection and output-enable bits. A sweep FSM then drives every input vector through the internal approximate datapath and accumulates the worst-case absolute error and the count of erroneous vectors. It reports pass/fail against the error threshold ET, giving hardware-side checking of synthesized candidate circuits.

## Interface
- N_IN, 4: circuit inputs, even. Operand a = vec[N_IN/2-1:0], operand b = vec[N_IN-1:N_IN/2].
- N_OUT, 3: circuit outputs; must equal N_IN/2+1. out0 is the LSB.
- PIT, 2: number of shared products.
- ET, 4: error threshold; pass when max_err <= ET.
- CFG_W, derived = 2*PIT*N_IN + PIT*N_OUT + N_OUT (25 at defaults); not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  config bit valid.
- cfg_bit  in  1  config data, LSB of the config word first.
- cfg_ready  out  1  config bit accepted when cfg_valid & cfg_ready.
- cfg_loaded  out  1  full CFG_W-bit word present.
- start  in  1  begin sweep (single-cycle pulse, sampled in IDLE).
- busy  out  1  high in LOAD, SWEEP, DRAIN.
- cur_vec  out  N_IN  vector currently issued to the datapath.
- done  out  1  one-cycle pulse when results are final.
- max_err  out  N_OUT  maximum |approx - exact| over all vectors.
- err_count  out  N_IN+1  number of vectors with nonzero error.
- pass  out  1  max_err <= ET, valid from done.

## Operation
- Config word fields, in bit-index order:
  - lit_use[p*N_IN+i]: input i appears in product p.
  - lit_pol[p*N_IN+i]: 1 = inverted literal.
  - sel[p*N_OUT+o]: product p feeds output o.
  - out_en[o]: 0 forces output o to 0.
- Product p = AND of its used literals. A product with no used literals evaluates to 0.
- Output o = out_en[o] & OR over p of (sel[p*N_OUT+o] & product p).
- approx = {out_{N_OUT-1}..out0}, zero-extended. exact = a + b, N_OUT bits.
- err = |approx - exact|, computed in N_OUT+1-bit signed arithmetic, stored in N_OUT bits (at most 2^N_OUT-1).
- FSM states:
  - IDLE: cfg_ready=1. A first accepted bit clears cfg_loaded and enters LOAD. start with cfg_loaded=1 enters SWEEP; start with cfg_loaded=0 is ignored.
  - LOAD: cfg_ready=1. Shifts one bit per accepted handshake, bit k lands at index k. After the CFG_W-th bit, sets cfg_loaded=1 and returns to IDLE. start is ignored.
  - SWEEP: cfg_ready=0. Issues cur_vec = 0..2^N_IN-1, one per cycle, then enters DRAIN. start is ignored.
  - DRAIN: two cycles to flush the pipeline, then DONE.
  - DONE: done=1 for one cycle, pass updated, then IDLE.
- max_err, err_count and pass clear on SWEEP entry and hold after DONE until the next start.
- The config register is held during SWEEP and DRAIN. A re-load after DONE overwrites all fields.
- cur_vec wraps to 0 after the last vector and holds 0 outside SWEEP.

## Timing
- Reset values: cfg_ready=1, cfg_loaded=0, busy=0, done=0, cur_vec=0, max_err=0, err_count=0, pass=0. Config register is all zeros; FSM in IDLE.
- Config: one bit per cycle at full rate. The last bit is accepted at cycle C; cfg_loaded=1 from C+1.
- Pipeline: vector registered (stage 0), error registered (stage 1), accumulators updated (stage 2).
- start accepted at cycle T:
  - busy=1 and cur_vec=0 at T+1.
  - Vector v is issued at T+1+v.
  - done pulses at T+2^N_IN+3 (T+19 at defaults), with final results visible in that same cycle.
- Reset asserted mid-LOAD or mid-SWEEP: immediately returns all outputs to reset values and discards partial config. No done pulse.

## Test plan
- Reset then no config; start pulse → no busy, no done, outputs stay 0.
- Load config with pr0=in1, pr1=in0&~in1, out_en=110, sel: pr0→out1,out2 and pr1→out2; start at T → done at T+19, max_err=4, err_count=13, pass=1. Same config with ET=3 → pass=0.
- All-zero config → max_err=6, err_count=15, pass=0 (ET=4).
- cfg_valid held high during SWEEP, plus a second start mid-sweep → cfg_ready=0, config and results unchanged, a single done at T+19.
- rst_n low at T+8 of a sweep → all outputs at reset values next cycle, cfg_loaded=0; reload and rerun gives identical results.
- Load 12 bits, then start → ignored (cfg_loaded=0). Remaining 13 bits then start → normal sweep.
